// File: rtl/bit_serializer_if.sv
// Load/serial bus of the bit serializer: upstream word handshake, shift enable,
// serial output and status toward the detector/control logic.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             enable;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid, enable,
    input  load_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  data_in, load_valid, enable,
    output load_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word holding buffer feeding a shifter that
// emits one bit per enabled clock, streaming back-to-back words with no gap.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  bit_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic             r_full;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_head;
  logic [WIDTH-1:0] w_next;

  assign w_accept = bus.load_valid && !r_full;
  assign w_last   = (r_state == SHIFT) && bus.enable && (r_cnt == LAST);
  assign w_head   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_next   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                              : {1'b0, r_shift[WIDTH-1:1]};

  // ser_out is decoded from the async-reset state so reset forces IDLE_BIT at once
  assign bus.ser_out    = (r_state == SHIFT) ? w_head : IDLE_BIT;
  assign bus.ser_valid  = (r_state == SHIFT) && bus.enable;
  assign bus.load_ready = !r_full;
  assign bus.busy       = (r_state == SHIFT) || r_full;
  assign bus.done       = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // accept needs an empty buffer, drain needs a full one: never both at once
      if (w_accept) begin
        r_buf  <= bus.data_in;
        r_full <= 1'b1;
      end else if (r_full && ((r_state == IDLE) || w_last)) begin
        r_full <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (r_full) begin
            r_shift <= r_buf;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.enable) begin
            if (r_cnt == LAST) begin
              r_done <= 1'b1;
              if (r_full) begin
                r_shift <= r_buf;
                r_cnt   <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_shift <= w_next;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances, expected
// bits queued at acceptance and popped by per-instance monitors on the falling edge.
module tb_bit_serializer;

  typedef struct {
    logic b;
    bit   last;
  } exp_t;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  exp_t qm[$];
  exp_t ql[$];
  bit   pend_m = 1'b0;
  bit   pend_l = 1'b0;

  bit_serializer_if #(.WIDTH(8)) bm ();
  bit_serializer_if #(.WIDTH(8)) bl ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bm)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one word on the chosen instance; queue its bit order once accepted.
  task automatic send(input bit lsb, input logic [7:0] w);
    bit r;
    bit ok = 1'b0;
    if (lsb) begin bl.data_in = w; bl.load_valid = 1'b1; end
    else     begin bm.data_in = w; bm.load_valid = 1'b1; end
    for (int k = 0; k < 40 && !ok; k++) begin
      r = lsb ? bl.load_ready : bm.load_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    if (lsb) bl.load_valid = 1'b0; else bm.load_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    else begin
      for (int i = 0; i < 8; i++) begin
        exp_t e;
        e.b    = lsb ? w[i] : w[7-i];
        e.last = (i == 7);
        if (lsb) ql.push_back(e); else qm.push_back(e);
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int k = 1; k <= 60 && n == 0; k++) begin
      @(negedge clk);
      if (bm.done) n = k;
    end
  endtask

  task automatic count_run(output int n);
    int k = 0;
    n = 0;
    @(negedge clk);
    while (!bm.ser_valid && k < 50) begin @(negedge clk); k++; end
    while (bm.ser_valid && n < 100) begin n++; @(negedge clk); end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qm.delete();
      pend_m = 1'b0;
    end else begin
      chk("done_m", 32'(bm.done), 32'(pend_m));
      pend_m = 1'b0;
      if (bm.ser_valid) begin
        if (qm.size() == 0) begin
          checks++; errors++;
          $display("FAIL bit_m_unexpected: got %0b expected none at %0t", bm.ser_out, $time);
        end else begin
          e = qm.pop_front();
          chk("bit_m", 32'(bm.ser_out), 32'(e.b));
          pend_m = e.last;
        end
      end else if (!bm.busy) begin
        chk("idle_m", 32'(bm.ser_out), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ql.delete();
      pend_l = 1'b0;
    end else begin
      chk("done_l", 32'(bl.done), 32'(pend_l));
      pend_l = 1'b0;
      if (bl.ser_valid) begin
        if (ql.size() == 0) begin
          checks++; errors++;
          $display("FAIL bit_l_unexpected: got %0b expected none at %0t", bl.ser_out, $time);
        end else begin
          e = ql.pop_front();
          chk("bit_l", 32'(bl.ser_out), 32'(e.b));
          pend_l = e.last;
        end
      end
    end
  end

  initial begin
    int n;
    int run;
    rst_n = 1'b0;
    bm.data_in = '0; bm.load_valid = 1'b0; bm.enable = 1'b1;
    bl.data_in = '0; bl.load_valid = 1'b0; bl.enable = 1'b1;
    #12;
    chk("rst_ready", 32'(bm.load_ready), 32'd1);
    chk("rst_ser",   32'(bm.ser_out),    32'd1);
    chk("rst_busy",  32'(bm.busy),       32'd0);
    chk("rst_done",  32'(bm.done),       32'd0);
    chk("rst_ready_l", 32'(bl.load_ready), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single word, latency to done
    send(1'b0, 8'b0110_0110);
    chk("ready_after_accept", 32'(bm.load_ready), 32'd0);
    chk("busy_after_accept",  32'(bm.busy),       32'd1);
    wait_done(n);
    chk("done_latency", 32'(n), 32'd10);
    repeat (3) @(posedge clk);
    #1;

    // back-to-back words stream gap-free
    send(1'b0, 8'hA5);
    chk("ready_E0", 32'(bm.load_ready), 32'd0);
    fork
      send(1'b0, 8'h3C);
      count_run(run);
    join
    chk("run_2words", 32'(run), 32'd16);
    repeat (4) @(posedge clk);
    #1;

    // pause for 3 edges after the 2nd bit
    send(1'b0, 8'hF0);
    fork
      wait_done(n);
      begin
        repeat (3) @(posedge clk);
        #1 bm.enable = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("pause_valid", 32'(bm.ser_valid), 32'd0);
          chk("pause_hold",  32'(bm.ser_out),   32'd1);
        end
        @(posedge clk);
        #1 bm.enable = 1'b1;
      end
    join
    chk("done_latency_pause", 32'(n), 32'd13);
    repeat (3) @(posedge clk);
    #1;

    // LSB-first instance
    send(1'b1, 8'b0000_0011);
    repeat (14) @(posedge clk);
    #1;

    // reset mid-word with a second word buffered
    send(1'b0, 8'hFF);
    send(1'b0, 8'h55);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ser",   32'(bm.ser_out),    32'd1);
    chk("abort_busy",  32'(bm.busy),       32'd0);
    chk("abort_ready", 32'(bm.load_ready), 32'd1);
    chk("abort_done",  32'(bm.done),       32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, 8'h81);
    repeat (12) @(posedge clk);
    #1;

    // continuous load_valid across 5 words
    fork
      begin
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        send(1'b0, 8'h44);
        send(1'b0, 8'hC5);
      end
      count_run(run);
    join
    chk("run_5words", 32'(run), 32'd40);

    repeat (20) @(negedge clk);
    chk("drain_m", 32'(qm.size()), 32'd0);
    chk("drain_l", 32'(ql.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the serial sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word.
- Shifts each word out one bit per enabled clock on ser_out, which drives the detector's serial input.
- Back-to-back words stream with no idle gap; a per-word done pulse and a busy flag go to the control logic.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.
IDLE_BIT, 1'b1, level driven on ser_out when no word is being shifted.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
data_in  input  WIDTH  parallel word; sampled when load_valid && load_ready.
load_valid  input  1  upstream has a word on data_in.
load_ready  output  1  holding buffer is empty; combinational from buffer-full flag only.
enable  input  1  shift enable; low freezes the shifter (pause).
ser_out  output  1  serial bit to the detector.
ser_valid  output  1  high when the bit on ser_out is consumed at the next edge (shifter active && enable).
busy  output  1  shifter active or buffer full.
done  output  1  one-cycle pulse, the cycle after the last bit of a word is consumed.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer empty, shifter IDLE, bit counter 0, ser_out=IDLE_BIT, done=0, busy=0.
  - load_ready=1, so it is also high during reset.
  - Any in-flight or buffered word is discarded; ser_out returns to IDLE_BIT immediately, not at the next edge.
- Storage:
  - Holding buffer: WIDTH bits plus a full flag.
  - Shifter: WIDTH-bit register plus a counter of width clog2(WIDTH).
  - Control FSM: two states, IDLE and SHIFT.
- Accept: at an edge with load_valid && load_ready, data_in goes into the buffer and the full flag sets. load_ready=0 while full; no simultaneous accept+drain.
- IDLE -> SHIFT: at any edge with the buffer full, the buffer moves into the shifter, the counter clears and the buffer empties. This happens regardless of enable.
- Latency: word accepted at edge E0 -> shifter loaded at E1 -> first bit on ser_out during E1..E2.
  - With enable held high, bits are consumed at E2..E(WIDTH+1).
  - done is high for the cycle after E(WIDTH+1).
- SHIFT:
  - ser_out = current head bit: MSB when MSB_FIRST=1, else LSB.
  - At an edge with enable=1: shift by one, counter+1.
  - At an edge with enable=0: shifter, counter and ser_out hold; ser_valid=0.
- Last bit (counter==WIDTH-1 && enable):
  - If buffer full: the next word loads into the shifter at that same edge, the counter clears and SHIFT is kept, giving zero-gap streaming.
  - If buffer empty: go to IDLE and ser_out=IDLE_BIT next cycle.
  - done pulses in both cases.
- done: registered; exactly one cycle per completed word; never asserted for a word aborted by reset.
- busy = (state==SHIFT) || buffer_full.
- data_in changes while load_ready=0 are ignored.

Test Plan:
- WIDTH=8, MSB_FIRST=1, enable=1; accept 8'b0110_0110 at E0 -> ser_out = 0,1,1,0,0,1,1,0 during cycles E1..E9; ser_valid high for exactly those 8 cycles; done high for the one cycle after E9; ser_out=1 afterwards.
- Two words, 8'hA5 then 8'h3C, offered back-to-back -> 16 consecutive ser_valid cycles, bit stream 10100101_00111100, two done pulses 8 cycles apart; load_ready low E0..E1 and again while the second word is buffered.
- Accept 8'hF0, drop enable for 3 cycles after the 2nd bit -> ser_out holds bit 2 (1) for 4 cycles, ser_valid=0 during the pause, done delayed by exactly 3 cycles.
- MSB_FIRST=0, accept 8'b0000_0011 -> ser_out = 1,1,0,0,0,0,0,0.
- Accept 8'hFF, assert rst_n=0 mid-word (after 4 bits) with a second word buffered -> ser_out=IDLE_BIT immediately, no done pulse, busy=0, load_ready=1; after release the next accepted word serializes from bit 0.
- Hold load_valid=1 continuously with distinct words for 5 words -> each word accepted exactly once, 40 gap-free bits in order, 5 done pulses.
